// File: rtl/fp_mul_seq.sv
// ---------------------------------------------------------------------------
// fp_mul_seq -- sequential IEEE-754 binary64 multiplier (responder side of the
// shared-operator valid/ready/finish handshake).
//
// The significand product is built by a radix-2^RADIX_BITS shift-add loop,
// LSB first. Every request walks IDLE -> UNPACK -> MUL (N cycles) -> NORM ->
// ROUND, so the latency is a fixed N+3 cycles for every operand class.
// N = ceil(53/RADIX_BITS).
//
// Numeric behaviour: round to nearest even, subnormal inputs read as signed
// zero, tiny results flush to signed zero, huge results saturate to inf.
// Every NaN result is the canonical quiet NaN 0x7FF8000000000000.
//
// Parameters:
//   DBL_WIDTH  : operand/result width, must be 64
//   RADIX_BITS : multiplier bits consumed per MUL cycle (1, 2 or 4)
//
// Ports:
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   valid  : request pulse; a/b are sampled when valid && ready
//   ready  : high while IDLE (including the finish cycle)
//   a, b   : binary64 operands
//   finish : one-cycle pulse, result valid in that cycle
//   result : product, held until the next finish
//   flags  : {invalid, div0, overflow, underflow, inexact}. This port exists
//            only when FP_MUL_EXC_FLAGS_EN is defined, and is registered with
//            result.
//
// Optional feature macro: FP_MUL_EXC_FLAGS_EN
// ---------------------------------------------------------------------------
module fp_mul_seq #(
  parameter int DBL_WIDTH  = 64,
  parameter int RADIX_BITS = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid,
  output logic                 ready,
  input  logic [DBL_WIDTH-1:0] a,
  input  logic [DBL_WIDTH-1:0] b,
  output logic                 finish,
  output logic [DBL_WIDTH-1:0] result
`ifdef FP_MUL_EXC_FLAGS_EN
  ,
  output logic [4:0]           flags
`endif
);

  // Number of MUL iterations, padded multiplier width and counter width.
  localparam int N  = (53 + RADIX_BITS - 1) / RADIX_BITS;
  localparam int MW = N * RADIX_BITS;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (DBL_WIDTH != 64) begin : g_bad_width
      $error("fp_mul_seq: only DBL_WIDTH=64 is supported");
    end
    if ((RADIX_BITS != 1) && (RADIX_BITS != 2) && (RADIX_BITS != 4)) begin : g_bad_radix
      $error("fp_mul_seq: RADIX_BITS must be 1, 2 or 4");
    end
  endgenerate

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_UNPACK = 3'd1,
    ST_MUL    = 3'd2,
    ST_NORM   = 3'd3,
    ST_ROUND  = 3'd4
  } state_t;

  // Special-case code, resolved in UNPACK and applied in ROUND.
  localparam logic [1:0] SP_NONE = 2'd0;
  localparam logic [1:0] SP_NAN  = 2'd1;
  localparam logic [1:0] SP_INF  = 2'd2;
  localparam logic [1:0] SP_ZERO = 2'd3;

  localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;

  // Classify both operands and apply the special-case priority:
  // NaN (including inf*0), then inf, then zero. exp==0 is zero (DAZ).
  function automatic logic [1:0] special_code(input logic [10:0] ea,
                                              input logic [51:0] fa,
                                              input logic [10:0] eb,
                                              input logic [51:0] fb);
    logic a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
    a_zero = (ea == 11'd0);
    a_inf  = (ea == 11'h7FF) && (fa == 52'd0);
    a_nan  = (ea == 11'h7FF) && (fa != 52'd0);
    b_zero = (eb == 11'd0);
    b_inf  = (eb == 11'h7FF) && (fb == 52'd0);
    b_nan  = (eb == 11'h7FF) && (fb != 52'd0);
    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
      return SP_NAN;
    end else if (a_inf || b_inf) begin
      return SP_INF;
    end else if (a_zero || b_zero) begin
      return SP_ZERO;
    end else begin
      return SP_NONE;
    end
  endfunction

  // Multiplicand times one radix digit, built from shifted copies.
  function automatic logic [105:0] radix_partial(input logic [105:0]          mc,
                                                 input logic [RADIX_BITS-1:0] digit);
    logic [105:0] sum;
    sum = 106'd0;
    for (int j = 0; j < RADIX_BITS; j++) begin
      sum = sum + (digit[j] ? (mc << j) : 106'd0);
    end
    return sum;
  endfunction

  state_t               state_r;
  logic [63:0]          a_r, b_r;
  logic                 sign_r;
  logic signed [12:0]   exp_r;
  logic [1:0]           spec_r;
  logic [105:0]         mcand_r;
  logic [MW-1:0]        mplier_r;
  logic [105:0]         acc_r;
  logic [CW-1:0]        cnt_r;
  logic [51:0]          frac_r;
  logic                 guard_r;
  logic                 sticky_r;
  logic                 finish_r;
  logic [63:0]          result_r;

  logic [10:0]          ea_s, eb_s;
  logic [51:0]          fa_s, fb_s;
  logic [1:0]           spec_s;
  logic signed [12:0]   exp_sum_s;
  logic [105:0]         acc_next_s;
  logic [51:0]          norm_frac_s;
  logic                 norm_guard_s;
  logic                 norm_sticky_s;
  logic signed [12:0]   norm_exp_s;
  logic                 round_up_s;
  logic [52:0]          frac_inc_s;
  logic signed [12:0]   exp_fin_s;
  logic                 ovf_s;
  logic                 unf_s;
  logic [63:0]          packed_s;

  assign ready  = (state_r == ST_IDLE);
  assign finish = finish_r;
  assign result = result_r;

  // Operand field split, classification and biased exponent sum.
  always_comb begin
    ea_s      = a_r[62:52];
    eb_s      = b_r[62:52];
    fa_s      = a_r[51:0];
    fb_s      = b_r[51:0];
    spec_s    = special_code(ea_s, fa_s, eb_s, fb_s);
    exp_sum_s = $signed({2'b00, ea_s}) + $signed({2'b00, eb_s}) - 13'sd1023;
  end

  // One shift-add step of the significand product.
  always_comb begin
    acc_next_s = acc_r + radix_partial(mcand_r, mplier_r[RADIX_BITS-1:0]);
  end

  // Normalise the product. It lies in [1,4) scaled by 2^104, so at most one
  // right shift is needed. The hidden bit is dropped here.
  always_comb begin
    if (acc_r[105]) begin
      norm_frac_s   = acc_r[104:53];
      norm_guard_s  = acc_r[52];
      norm_sticky_s = |acc_r[51:0];
      norm_exp_s    = exp_r + 13'sd1;
    end else begin
      norm_frac_s   = acc_r[103:52];
      norm_guard_s  = acc_r[51];
      norm_sticky_s = |acc_r[50:0];
      norm_exp_s    = exp_r;
    end
  end

  // Round to nearest even, range check, and pack the final encoding.
  always_comb begin
    round_up_s = guard_r & (sticky_r | frac_r[0]);
    frac_inc_s = {1'b0, frac_r} + {52'd0, round_up_s};
    // A carry out of the fraction means the mantissa rolled over to 1.0 at
    // the next exponent. The fraction bits are then already zero.
    exp_fin_s  = exp_r + (frac_inc_s[52] ? 13'sd1 : 13'sd0);
    ovf_s      = (spec_r == SP_NONE) && (exp_fin_s >= 13'sd2047);
    unf_s      = (spec_r == SP_NONE) && !ovf_s && (exp_fin_s <= 13'sd0);
    case (spec_r)
      SP_NAN:  packed_s = QNAN;
      SP_INF:  packed_s = {sign_r, 11'h7FF, 52'd0};
      SP_ZERO: packed_s = {sign_r, 63'd0};
      SP_NONE: begin
        if (ovf_s) begin
          packed_s = {sign_r, 11'h7FF, 52'd0};
        end else if (unf_s) begin
          packed_s = {sign_r, 63'd0};
        end else begin
          packed_s = {sign_r, exp_fin_s[10:0], frac_inc_s[51:0]};
        end
      end
      default: packed_s = QNAN;
    endcase
  end

`ifdef FP_MUL_EXC_FLAGS_EN
  logic [4:0] flags_r;
  logic [4:0] flags_s;

  assign flags = flags_r;

  // Exception flags for the operation being rounded.
  always_comb begin
    flags_s = {(spec_r == SP_NAN),
               1'b0,
               ovf_s,
               unf_s,
               (spec_r == SP_NONE) && (guard_r | sticky_r | ovf_s | unf_s)};
  end
`endif

  // Control FSM and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      a_r      <= 64'd0;
      b_r      <= 64'd0;
      sign_r   <= 1'b0;
      exp_r    <= 13'sd0;
      spec_r   <= SP_NONE;
      mcand_r  <= 106'd0;
      mplier_r <= {MW{1'b0}};
      acc_r    <= 106'd0;
      cnt_r    <= {CW{1'b0}};
      frac_r   <= 52'd0;
      guard_r  <= 1'b0;
      sticky_r <= 1'b0;
      finish_r <= 1'b0;
      result_r <= 64'd0;
`ifdef FP_MUL_EXC_FLAGS_EN
      flags_r  <= 5'd0;
`endif
    end else begin
      finish_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (valid && ready) begin
            a_r     <= a;
            b_r     <= b;
            state_r <= ST_UNPACK;
          end
        end
        ST_UNPACK: begin
          sign_r   <= a_r[63] ^ b_r[63];
          exp_r    <= exp_sum_s;
          spec_r   <= spec_s;
          mcand_r  <= {53'd0, 1'b1, fa_s};
          mplier_r <= MW'({1'b1, fb_s});
          acc_r    <= 106'd0;
          cnt_r    <= {CW{1'b0}};
          state_r  <= ST_MUL;
        end
        ST_MUL: begin
          acc_r    <= acc_next_s;
          mcand_r  <= mcand_r << RADIX_BITS;
          mplier_r <= mplier_r >> RADIX_BITS;
          if (cnt_r == CW'(N - 1)) begin
            cnt_r   <= {CW{1'b0}};
            state_r <= ST_NORM;
          end else begin
            cnt_r   <= cnt_r + CW'(1);
          end
        end
        ST_NORM: begin
          frac_r   <= norm_frac_s;
          guard_r  <= norm_guard_s;
          sticky_r <= norm_sticky_s;
          exp_r    <= norm_exp_s;
          state_r  <= ST_ROUND;
        end
        ST_ROUND: begin
          result_r <= packed_s;
          finish_r <= 1'b1;
`ifdef FP_MUL_EXC_FLAGS_EN
          flags_r  <= flags_s;
`endif
          state_r  <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mul_seq.sv
// ---------------------------------------------------------------------------
// tb_fp_mul_seq -- self-checking bench for fp_mul_seq.
// Three instances (RADIX_BITS = 2, 1, 4), each with its own inputs and reset.
// Directed cases use constant expectations. Random cases are checked against
// a model built on the simulator's binary64 real arithmetic plus DAZ/FTZ
// rules.
// ---------------------------------------------------------------------------
module tb_fp_mul_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]        rst_v = 3'b000;
  logic [2:0]        vld_v = 3'b000;
  logic [2:0][63:0]  a_v   = '0;
  logic [2:0][63:0]  b_v   = '0;
  logic [2:0]        rdy_v;
  logic [2:0]        fin_v;
  logic [2:0][63:0]  res_v;
`ifdef FP_MUL_EXC_FLAGS_EN
  logic [2:0][4:0]   flg_v;
`endif

  localparam int LAT [3] = '{30, 56, 17};

  int total = 0;
  int bad   = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int RB = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
    fp_mul_seq #(.DBL_WIDTH(64), .RADIX_BITS(RB)) u_dut (
      .clk    (clk),
      .rst_n  (rst_v[g]),
      .valid  (vld_v[g]),
      .ready  (rdy_v[g]),
      .a      (a_v[g]),
      .b      (b_v[g]),
      .finish (fin_v[g]),
      .result (res_v[g])
`ifdef FP_MUL_EXC_FLAGS_EN
      ,
      .flags  (flg_v[g])
`endif
    );
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic real p2(input int k);
    real r;
    r = 1.0;
    if (k >= 0) begin
      for (int i = 0; i < k; i++) r = r * 2.0;
    end else begin
      for (int i = 0; i < -k; i++) r = r / 2.0;
    end
    return r;
  endfunction

  // Reference product: special-case rules first, then a binary64 real
  // multiply. Results in the tiny range are recomputed with scaled operands,
  // so rounding happens at 53 bits before the flush-to-zero decision.
  task automatic ref_mul(input logic [63:0] x, input logic [63:0] y,
                         output logic [63:0] r, output logic [4:0] f);
    logic [10:0]  ex, ey;
    logic [51:0]  fx, fy;
    logic         s, zx, zy, ix, iy, nx, ny, inexact;
    logic [105:0] sp;
    logic [63:0]  pb;
    real          mx, my, p, rs;
    ex = x[62:52]; ey = y[62:52]; fx = x[51:0]; fy = y[51:0];
    s  = x[63] ^ y[63];
    zx = (ex == 11'd0);  zy = (ey == 11'd0);
    ix = (ex == 11'h7FF) && (fx == 52'd0);  iy = (ey == 11'h7FF) && (fy == 52'd0);
    nx = (ex == 11'h7FF) && (fx != 52'd0);  ny = (ey == 11'h7FF) && (fy != 52'd0);
    f  = 5'd0;
    if (nx || ny || (ix && zy) || (zx && iy)) begin
      r = 64'h7FF8_0000_0000_0000;
      f = 5'b10000;
    end else if (ix || iy) begin
      r = {s, 11'h7FF, 52'd0};
    end else if (zx || zy) begin
      r = {s, 63'd0};
    end else begin
      sp = {53'd0, 1'b1, fx} * {53'd0, 1'b1, fy};
      inexact = sp[105] ? (sp[52:0] != 53'd0) : (sp[51:0] != 52'd0);
      mx = $bitstoreal({1'b0, x[62:0]});
      my = $bitstoreal({1'b0, y[62:0]});
      p  = mx * my;
      pb = $realtobits(p);
      if (pb[62:52] == 11'h7FF) begin
        r = {s, 11'h7FF, 52'd0};
        f = 5'b00101;
      end else if (p < p2(-1000)) begin
        rs = (mx * p2(550)) * (my * p2(550));
        if (rs < p2(78)) begin
          r = {s, 63'd0};
          f = 5'b00011;
        end else begin
          pb = $realtobits((rs * p2(-550)) * p2(-550));
          r  = {s, pb[62:0]};
          f  = {4'b0000, inexact};
        end
      end else begin
        r = {s, pb[62:0]};
        f = {4'b0000, inexact};
      end
    end
  endtask

  function automatic logic [63:0] rand_op();
    logic [63:0] raw;
    logic [10:0] e;
    logic [51:0] f;
    int          cls;
    raw = {$urandom, $urandom};
    f   = raw[51:0];
    cls = $urandom_range(0, 15);
    case (cls)
      0:             begin e = 11'd0;    f = 52'd0;         end
      1:             begin e = 11'd0;    f = f | 52'd1;     end
      2:             begin e = 11'h7FF;  f = 52'd0;         end
      3:             begin e = 11'h7FF;  f = f | 52'd1;     end
      4, 5, 6, 7, 8: begin e = 11'($urandom_range(1, 2046)); end
      9:             begin e = 11'($urandom_range(960, 1090)); f = 52'hF_FFFF_FFFF_FFFF; end
      default:       begin e = 11'($urandom_range(960, 1090)); end
    endcase
    return {raw[63], e, f};
  endfunction

  // Present one request at a negedge. Returns one cycle later (cycle 0 after accept).
  task automatic issue(input int u, input logic [63:0] x, input logic [63:0] y);
    a_v[u]   = x;
    b_v[u]   = y;
    vld_v[u] = 1'b1;
    @(negedge clk);
    vld_v[u] = 1'b0;
  endtask

  // Wait (bounded) for finish and check latency, busy/ready behaviour and
  // result. The task returns in the finish cycle.
  task automatic await_done(input int u, input int start, input logic [63:0] er,
                            input logic [4:0] ef, input string tag);
    int cyc;
    bit busy_ok;
    cyc     = start;
    busy_ok = 1'b1;
    while (!fin_v[u] && (cyc < 200)) begin
      if (rdy_v[u]) busy_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    chk({tag, " finish"}, 64'(fin_v[u]), 64'd1);
    chk({tag, " latency"}, 64'(cyc), 64'(LAT[u]));
    chk({tag, " busy"}, 64'(busy_ok), 64'd1);
    chk({tag, " ready"}, 64'(rdy_v[u]), 64'd1);
    chk({tag, " result"}, res_v[u], er);
`ifdef FP_MUL_EXC_FLAGS_EN
    chk({tag, " flags"}, 64'(flg_v[u]), 64'(ef));
`else
    if (ef === 5'bxxxxx) $display("note: flags unknown for %s", tag);
`endif
  endtask

  localparam logic [63:0] D2 = 64'h4000_0000_0000_0000;
  localparam logic [63:0] D3 = 64'h4008_0000_0000_0000;
  localparam logic [63:0] D5 = 64'h4014_0000_0000_0000;
  localparam logic [63:0] D6 = 64'h4018_0000_0000_0000;

  logic [63:0] dx [7] = '{64'h3FF0_0000_0000_0001, 64'h7FF0_0000_0000_0000,
                          64'h8000_0000_0000_0000, 64'h7FEF_FFFF_FFFF_FFFF,
                          64'h0010_0000_0000_0000, 64'h0000_0000_0000_0001,
                          64'hFFF0_0000_0000_0000};
  logic [63:0] dy [7] = '{64'h3FF0_0000_0000_0001, 64'h0000_0000_0000_0000,
                          64'h4014_0000_0000_0000, 64'h4000_0000_0000_0000,
                          64'h3FE0_0000_0000_0000, 64'h4000_0000_0000_0000,
                          64'h4000_0000_0000_0000};
  logic [63:0] dr [7] = '{64'h3FF0_0000_0000_0002, 64'h7FF8_0000_0000_0000,
                          64'h8000_0000_0000_0000, 64'h7FF0_0000_0000_0000,
                          64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000,
                          64'hFFF0_0000_0000_0000};
  logic [4:0]  df [7] = '{5'b00001, 5'b10000, 5'b00000, 5'b00101,
                          5'b00011, 5'b00000, 5'b00000};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] x, y, er;
    logic [4:0]  ef;
    bit          seen;

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      chk($sformatf("rst ready u%0d", u), 64'(rdy_v[u]), 64'd1);
      chk($sformatf("rst finish u%0d", u), 64'(fin_v[u]), 64'd0);
      chk($sformatf("rst result u%0d", u), res_v[u], 64'd0);
    end
    rst_v = 3'b111;
    @(negedge clk);

    // 2.0*3.0 with latency, then back-to-back 5.0*5.0 issued in the finish cycle.
    issue(0, D2, D3);
    await_done(0, 0, D6, 5'b00000, "mul23");
    issue(0, D5, D5);
    chk("finish pulse width", 64'(fin_v[0]), 64'd0);
    await_done(0, 0, 64'h4039_0000_0000_0000, 5'b00000, "b2b55");

    // Directed rounding, special, overflow, underflow and DAZ cases.
    for (int i = 0; i < 7; i++) begin
      issue(0, dx[i], dy[i]);
      await_done(0, 0, dr[i], df[i], $sformatf("dir%0d", i));
    end

    // A request while busy is ignored.
    issue(0, D2, D3);
    repeat (4) @(negedge clk);
    a_v[0] = D5; b_v[0] = D5; vld_v[0] = 1'b1;
    chk("busy ready", 64'(rdy_v[0]), 64'd0);
    @(negedge clk);
    vld_v[0] = 1'b0;
    await_done(0, 5, D6, 5'b00000, "busy");

    // Reset asserted mid-MUL on every radix, then recovery.
    for (int u = 0; u < 3; u++) begin
      @(negedge clk);
      issue(u, D2, D3);
      repeat (5) @(negedge clk);
      rst_v[u] = 1'b0;
      @(negedge clk);
      chk($sformatf("abort ready u%0d", u), 64'(rdy_v[u]), 64'd1);
      chk($sformatf("abort result u%0d", u), res_v[u], 64'd0);
      rst_v[u] = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < LAT[u] + 5; k++) begin
        if (fin_v[u]) seen = 1'b1;
        @(negedge clk);
      end
      chk($sformatf("abort no finish u%0d", u), 64'(seen), 64'd0);
      issue(u, D2, D3);
      await_done(u, 0, D6, 5'b00000, $sformatf("recover u%0d", u));
    end

    // Randomized operands against the reference model, issued back to back.
    for (int u = 0; u < 3; u++) begin
      for (int i = 0; i < ((u == 0) ? 40 : 15); i++) begin
        x = rand_op();
        y = rand_op();
        ref_mul(x, y, er, ef);
        issue(u, x, y);
        await_done(u, 0, er, ef, $sformatf("rnd u%0d #%0d %h*%h", u, i, x, y));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_mul_seq.md
Name: fp_mul_seq

Overview:
Sequential IEEE-754 binary64 multiplier that sits on the responder side of the shared-operator valid/ready/finish handshake used by the CMU compute units. An initiator pulses valid with operands. The block computes a*b with a radix-2^RADIX_BITS shift-add mantissa datapath, then returns result with a one-cycle finish pulse after a fixed latency. It is area-lean and intended where a CMU shares one multiplier across many products.

Parameters:
DBL_WIDTH, 64, operand/result width; only 64 is supported, elaboration error otherwise.
RADIX_BITS, 2, multiplier bits consumed per MUL cycle; legal values are 1, 2 and 4.

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
valid  input  1  one-cycle request pulse; a and b are sampled when valid && ready
ready  output  1  high when the block can accept a request (state IDLE)
a  input  DBL_WIDTH  operand A, binary64
b  input  DBL_WIDTH  operand B, binary64
finish  output  1  one-cycle pulse; result is valid in this cycle
result  output  DBL_WIDTH  product; held until the next finish

Behaviour:
- Reset (async, rst_n low): state=IDLE, finish=0, result=0, all internal registers 0. ready=(state==IDLE), so ready reads 1 during and after reset.
- States and transitions:
  - IDLE: on valid&&ready at an edge, capture a and b, go to UNPACK.
  - UNPACK (1 cycle): split fields; classify each operand as zero, normal, inf or NaN; load the 53-bit significands (hidden bit 1); compute exponent sum ea+eb-1023 in 13-bit signed arithmetic; sign = sa^sb.
  - MUL (N cycles, N=ceil(53/RADIX_BITS); N=53/27/14 for RADIX_BITS=1/2/4): each cycle adds the multiplicand times RADIX_BITS multiplier bits into a 106-bit accumulator, LSB first. The multiplier is zero-extended to N*RADIX_BITS bits. A cycle counter counts 0..N-1.
  - NORM (1 cycle): if product bit105=1, exp+1 and take 53 bits from [105:53]; else take 53 bits from [104:52]. Guard is the next bit; sticky is the OR of all lower bits.
  - ROUND (1 cycle): round to nearest, ties to even. A mantissa carry-out increments exp. Write result, pulse finish, return to IDLE.
- Latency: valid sampled at edge E gives finish=1 in the cycle after edge E+N+3. This is L=N+3 cycles for every operand class; special cases still traverse all states.
- ready=0 from the cycle after accept through ROUND. ready=1 in the finish cycle, so a valid in the finish cycle is accepted (back-to-back issue).
- valid while ready=0 is ignored: no queueing, no effect on the in-flight operation.
- a and b need only be stable at the accepting edge.
- Special cases (resolved in ROUND, priority in this order):
  1. Either operand NaN, or inf*0 → canonical qNaN 0x7FF8000000000000.
  2. Inf*nonzero → inf with xor sign.
  3. Either operand zero → zero with xor sign.
- Subnormal inputs (exp=0, frac≠0) are treated as signed zero (DAZ).
- Exponent handling after rounding:
  - final exp ≥ 2047 → inf with sign (overflow).
  - final exp ≤ 0 → signed zero (flush-to-zero, no subnormal output).
- Reset mid-operation: the operation is aborted, no finish is issued, and the block is in IDLE on the first edge after release.

Optional Feature:
FP_MUL_EXC_FLAGS_EN: when defined, adds output port flags [4:0] = {invalid, div0(always 0), overflow, underflow, inexact}.
- flags is registered with result, valid in the finish cycle, and holds until the next finish. Reset value is 0.
- invalid: a NaN result was produced by rule 1.
- overflow: the result saturated to inf from finite operands.
- underflow: the result was flushed to zero from nonzero finite operands.
- inexact: guard|sticky was set, or overflow or underflow occurred.
When undefined, the port and its logic are absent; all other behaviour is identical.

Test Plan:
1. RADIX_BITS=2: a=0x4000000000000000 (2.0), b=0x4008000000000000 (3.0) → result=0x4018000000000000. finish exactly 30 cycles after accept; ready=0 in between; ready=1 in the finish cycle.
2. a=b=0x3FF0000000000001 → result=0x3FF0000000000002 (RNE discards 2^-104); inexact=1 when FP_MUL_EXC_FLAGS_EN is defined.
3. Specials:
   - inf*0 → 0x7FF8000000000000 (invalid=1).
   - 0x8000000000000000*0x4014000000000000 → 0x8000000000000000.
   - 0x7FEFFFFFFFFFFFFF*0x4000000000000000 → 0x7FF0000000000000 (overflow=1).
   All with latency L.
4. Underflow: 0x0010000000000000*0x3FE0000000000000 → 0x0000000000000000 (underflow=1). Subnormal 0x0000000000000001*0x4000000000000000 → 0x0000000000000000.
5. Back-to-back and busy:
   - Issue 2.0*3.0, then pulse valid mid-MUL with 5.0*5.0 → ignored; result=0x4018000000000000.
   - Pulse valid in the finish cycle with 5.0*5.0 → accepted; next finish L cycles later with 0x4039000000000000.
6. Assert rst_n low during MUL → finish never pulses for that op; result=0; ready=1. A subsequent 2.0*3.0 returns 0x4018000000000000 with latency L. Repeat with RADIX_BITS=1 (L=56) and RADIX_BITS=4 (L=17).
